// File: rtl/dcache_mem_responder_if.sv
// dcache_mem_responder_if: cache-side fill/store request and
// response bundle between the LSU data cache and its responder.
interface dcache_mem_responder_if #(
  parameter int TAG_BITS     = 22,
  parameter int INDEX_BITS   = 5,
  parameter int LINE_BITS    = 256,
  parameter int DATA_BITS    = 32,
  parameter int ST_ADDR_BITS = 30
);
  logic [TAG_BITS+INDEX_BITS-1:0] dc2memLdAddr_i;
  logic                           dc2memLdValid_i;
  logic [TAG_BITS-1:0]            mem2dcLdTag_o;
  logic [INDEX_BITS-1:0]          mem2dcLdIndex_o;
  logic [LINE_BITS-1:0]           mem2dcLdData_o;
  logic                           mem2dcLdValid_o;
  logic [ST_ADDR_BITS-1:0]        dc2memStAddr_i;
  logic [DATA_BITS-1:0]           dc2memStData_i;
  logic [DATA_BITS/8-1:0]         dc2memStByteEn_i;
  logic                           dc2memStValid_i;
  logic                           mem2dcStComplete_o;
  logic                           mem2dcStStall_o;

  modport master (
    output dc2memLdAddr_i, dc2memLdValid_i,
    output dc2memStAddr_i, dc2memStData_i,
    output dc2memStByteEn_i, dc2memStValid_i,
    input  mem2dcLdTag_o, mem2dcLdIndex_o,
    input  mem2dcLdData_o, mem2dcLdValid_o,
    input  mem2dcStComplete_o, mem2dcStStall_o
  );

  modport slave (
    input  dc2memLdAddr_i, dc2memLdValid_i,
    input  dc2memStAddr_i, dc2memStData_i,
    input  dc2memStByteEn_i, dc2memStValid_i,
    output mem2dcLdTag_o, mem2dcLdIndex_o,
    output mem2dcLdData_o, mem2dcLdValid_o,
    output mem2dcStComplete_o, mem2dcStStall_o
  );
endinterface

// File: rtl/dcache_mem_responder.sv
// dcache_mem_responder: queues dcache line fills and word stores
// and services them one at a time against a word-wide memory.
module dcache_mem_responder #(
  parameter int TAG_BITS     = 22,
  parameter int INDEX_BITS   = 5,
  parameter int LINE_BITS    = 256,
  parameter int DATA_BITS    = 32,
  parameter int ST_ADDR_BITS = 30,
  parameter int LDQ_DEPTH    = 4,
  parameter int STQ_DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  dcache_mem_responder_if.slave    dc,
  output logic [ST_ADDR_BITS-1:0]  memAddr_o,
  output logic                     memWe_o,
  output logic [DATA_BITS/8-1:0]   memBe_o,
  output logic [DATA_BITS-1:0]     memWrData_o,
  input  logic [DATA_BITS-1:0]     memRdData_i,
  output logic                     ldOverflow_o,
  output logic                     stOverflow_o
);
  localparam int LA_BITS = TAG_BITS + INDEX_BITS;
  localparam int BE_BITS = DATA_BITS / 8;
  localparam int WORDS   = LINE_BITS / DATA_BITS;
  localparam int WBITS   = $clog2(WORDS);
  localparam int LQ_PW   = $clog2(LDQ_DEPTH);
  localparam int SQ_PW   = $clog2(STQ_DEPTH);
  localparam logic [LQ_PW:0] LQ_FULL = (LQ_PW+1)'(LDQ_DEPTH);
  localparam logic [SQ_PW:0] SQ_FULL = (SQ_PW+1)'(STQ_DEPTH);
  localparam logic [WBITS-1:0] WLAST = WBITS'(WORDS-1);

  typedef enum logic [2:0] {
    IDLE, STORE, FILL, DRAIN, RESP
  } state_t;

  state_t state, stateNxt;

  logic [LA_BITS-1:0]      ldQ [LDQ_DEPTH];
  logic [LQ_PW-1:0]        ldWr, ldRd;
  logic [LQ_PW:0]          ldCnt;
  logic                    ldFull, ldEmpty;
  logic                    ldPush, ldPop;

  logic [ST_ADDR_BITS-1:0] stAddrQ [STQ_DEPTH];
  logic [DATA_BITS-1:0]    stDataQ [STQ_DEPTH];
  logic [BE_BITS-1:0]      stBeQ   [STQ_DEPTH];
  logic [SQ_PW-1:0]        stWr, stRd;
  logic [SQ_PW:0]          stCnt;
  logic                    stFull, stEmpty;
  logic                    stPush, stPop;

  logic [LA_BITS-1:0]      lineAddr;
  logic [WBITS-1:0]        wCnt, wPrev, wNext;
  logic [WORDS-1:0][DATA_BITS-1:0] lineBuf;
  logic                    ldValid, stComplete;

  assign ldFull  = ldCnt == LQ_FULL;
  assign ldEmpty = ldCnt == '0;
  assign ldPush  = dc.dc2memLdValid_i && !ldFull;
  assign stFull  = stCnt == SQ_FULL;
  assign stEmpty = stCnt == '0;
  assign stPush  = dc.dc2memStValid_i && !stFull;
  assign wPrev   = wCnt - WBITS'(1);
  assign wNext   = wCnt + WBITS'(1);

  assign dc.mem2dcStStall_o    = stFull;
  assign dc.mem2dcLdValid_o    = ldValid;
  assign dc.mem2dcStComplete_o = stComplete;
  assign dc.mem2dcLdTag_o      = lineAddr[LA_BITS-1:INDEX_BITS];
  assign dc.mem2dcLdIndex_o    = lineAddr[INDEX_BITS-1:0];
  assign dc.mem2dcLdData_o     = lineBuf;

  // Request FIFO storage; entries are only meaningful under count.
  always_ff @(posedge clk) begin
    if (ldPush) ldQ[ldWr] <= dc.dc2memLdAddr_i;
    if (stPush) begin
      stAddrQ[stWr] <= dc.dc2memStAddr_i;
      stDataQ[stWr] <= dc.dc2memStData_i;
      stBeQ[stWr]   <= dc.dc2memStByteEn_i;
    end
  end

  // FIFO pointers, counts and sticky drop flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      ldWr         <= '0;
      ldRd         <= '0;
      ldCnt        <= '0;
      stWr         <= '0;
      stRd         <= '0;
      stCnt        <= '0;
      ldOverflow_o <= 1'b0;
      stOverflow_o <= 1'b0;
    end else begin
      if (ldPush) ldWr <= ldWr + 1'b1;
      if (ldPop)  ldRd <= ldRd + 1'b1;
      if (stPush) stWr <= stWr + 1'b1;
      if (stPop)  stRd <= stRd + 1'b1;
      ldCnt <= ldCnt + {{LQ_PW{1'b0}}, ldPush}
                     - {{LQ_PW{1'b0}}, ldPop};
      stCnt <= stCnt + {{SQ_PW{1'b0}}, stPush}
                     - {{SQ_PW{1'b0}}, stPop};
      if (dc.dc2memLdValid_i && ldFull) ldOverflow_o <= 1'b1;
      if (dc.dc2memStValid_i && stFull) stOverflow_o <= 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNxt;
  end

  // Next state and pops; stores always win over fills.
  always_comb begin
    stateNxt = state;
    ldPop    = 1'b0;
    stPop    = 1'b0;
    unique case (state)
      IDLE: begin
        if (!stEmpty) begin
          stPop    = 1'b1;
          stateNxt = STORE;
        end else if (!ldEmpty) begin
          ldPop    = 1'b1;
          stateNxt = FILL;
        end
      end
      STORE: stateNxt = IDLE;
      FILL:  if (wCnt == WLAST) stateNxt = DRAIN;
      DRAIN: stateNxt = RESP;
      RESP:  stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  // Registered memory strobes, fill sequencing and line capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      memAddr_o   <= '0;
      memWe_o     <= 1'b0;
      memBe_o     <= '0;
      memWrData_o <= '0;
      ldValid     <= 1'b0;
      stComplete  <= 1'b0;
      lineAddr    <= '0;
      wCnt        <= '0;
      lineBuf     <= '0;
    end else begin
      memAddr_o   <= '0;
      memWe_o     <= 1'b0;
      memBe_o     <= '0;
      memWrData_o <= '0;
      ldValid     <= state == DRAIN;
      stComplete  <= state == STORE;
      if (stPop) begin
        memWe_o     <= 1'b1;
        memAddr_o   <= stAddrQ[stRd];
        memBe_o     <= stBeQ[stRd];
        memWrData_o <= stDataQ[stRd];
      end
      if (ldPop) begin
        lineAddr  <= ldQ[ldRd];
        wCnt      <= '0;
        memAddr_o <= {ldQ[ldRd], {WBITS{1'b0}}};
      end
      if (state == FILL) begin
        wCnt <= wNext;
        if (wCnt != WLAST) memAddr_o <= {lineAddr, wNext};
        if (wCnt != '0) lineBuf[wPrev] <= memRdData_i;
      end
      if (state == DRAIN) lineBuf[WLAST] <= memRdData_i;
    end
  end
endmodule
